// File: rtl/mult_pkg.sv
// Shared types and helpers for the iterative multiplier: FSM state encoding,
// DIGIT_BITS legality check and the golden product model used by benches.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Widest operand the reference model supports.
    localparam int REF_W = 64;

    function automatic bit digit_bits_legal(input int digit_bits);
        return (digit_bits == 1) || (digit_bits == 2) || (digit_bits == 4);
    endfunction

    // Full 2*width-bit product; operands occupy the low `width` bits of a and b.
    // Sign-extending to 2*REF_W and truncating yields the exact two's complement result.
    function automatic logic [2*REF_W-1:0] mult_ref(input logic [REF_W-1:0] a,
                                                    input logic [REF_W-1:0] b,
                                                    input logic is_signed,
                                                    input int width);
        logic [2*REF_W-1:0] ext_a;
        logic [2*REF_W-1:0] ext_b;
        logic [2*REF_W-1:0] prod;
        ext_a = '0;
        ext_b = '0;
        for (int i = 0; i < 2*REF_W; i++) begin
            if (i < width) begin
                ext_a[i] = a[i];
                ext_b[i] = b[i];
            end else if (is_signed) begin
                ext_a[i] = a[width-1];
                ext_b[i] = b[width-1];
            end
        end
        prod = ext_a * ext_b;
        for (int i = 0; i < 2*REF_W; i++) begin
            if (i >= 2*width) prod[i] = 1'b0;
        end
        return prod;
    endfunction

endpackage

// File: rtl/mult_sign_fix.sv
// Conditional two's complement negate; used for operand magnitudes and for
// restoring the sign of the final product.
module mult_sign_fix
    import mult_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] value,
    input  logic         negate,
    output logic [W-1:0] result
);

    assign result = negate ? (~value + 1'b1) : value;

endmodule

// File: rtl/mult_iter.sv
// Multi-cycle radix-2^DIGIT_BITS shift-add multiplier with valid/ready handshakes.
// Optional build macro MULT_ITER_EARLY_EXIT_EN finishes as soon as the multiplier runs out of set bits.
module mult_iter
    import mult_pkg::*;
#(
    parameter int  WIDTH      = 32,
    parameter int  DIGIT_BITS = 2,
    localparam int CNT_W      = $clog2(WIDTH/DIGIT_BITS) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_y
);

    localparam int NUM_DIGITS = WIDTH / DIGIT_BITS;
    localparam int PROD_W     = 2 * WIDTH;

    generate
        if (!digit_bits_legal(DIGIT_BITS) || (WIDTH % DIGIT_BITS) != 0) begin : g_bad_cfg
            $error("mult_iter: DIGIT_BITS must be 1, 2 or 4 and divide WIDTH");
        end
    endgenerate

    state_t state;
    state_t next_state;

    logic [WIDTH-1:0]  a_mag_in;
    logic [WIDTH-1:0]  b_mag_in;
    logic [PROD_W-1:0] mcand;
    logic [WIDTH-1:0]  b_rem;
    logic [PROD_W-1:0] acc;
    logic [CNT_W-1:0]  cnt;
    logic              neg_flag;

    logic [PROD_W-1:0] digit_ext;
    logic [PROD_W-1:0] partial;
    logic [PROD_W-1:0] acc_next;
    logic [WIDTH-1:0]  b_next;
    logic [PROD_W-1:0] y_fixed;
    logic              finish;
    logic              accept;

    mult_sign_fix #(.W(WIDTH)) u_fix_a (
        .value  (in_a),
        .negate (in_signed & in_a[WIDTH-1]),
        .result (a_mag_in)
    );

    mult_sign_fix #(.W(WIDTH)) u_fix_b (
        .value  (in_b),
        .negate (in_signed & in_b[WIDTH-1]),
        .result (b_mag_in)
    );

    mult_sign_fix #(.W(PROD_W)) u_fix_y (
        .value  (acc_next),
        .negate (neg_flag),
        .result (y_fixed)
    );

    // mcand is kept pre-shifted, so each digit's partial product is a plain multiply.
    always_comb begin
        digit_ext = {{(PROD_W-DIGIT_BITS){1'b0}}, b_rem[DIGIT_BITS-1:0]};
        partial   = mcand * digit_ext;
        acc_next  = acc + partial;
        b_next    = b_rem >> DIGIT_BITS;
    end

`ifdef MULT_ITER_EARLY_EXIT_EN
    assign finish = (cnt == CNT_W'(1)) || (b_next == '0);
`else
    assign finish = (cnt == CNT_W'(1));
`endif

    assign accept = (state == IDLE) && in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) next_state = CALC;
            end
            CALC: begin
                if (finish) next_state = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand    <= '0;
            b_rem    <= '0;
            acc      <= '0;
            cnt      <= '0;
            neg_flag <= 1'b0;
            out_y    <= '0;
        end else if (accept) begin
            mcand    <= {{WIDTH{1'b0}}, a_mag_in};
            b_rem    <= b_mag_in;
            acc      <= '0;
            cnt      <= CNT_W'(NUM_DIGITS);
            neg_flag <= in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
        end else if (state == CALC) begin
            mcand <= mcand << DIGIT_BITS;
            b_rem <= b_next;
            acc   <= acc_next;
            cnt   <= cnt - CNT_W'(1);
            if (finish) out_y <= y_fixed;
        end
    end

endmodule

// File: tb/tb_mult_iter.sv
// Directed and random checks of mult_iter at default parameters: products,
// latency, back-pressure hold and asynchronous reset during a calculation.
module tb_mult_iter;
    import mult_pkg::*;

    localparam int W  = 32;
    localparam int DB = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   in_a = '0;
    logic [W-1:0]   in_b = '0;
    logic           in_signed = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [2*W-1:0] out_y;

    int checks = 0;
    int errors = 0;

    mult_iter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_signed (in_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic           s;
        logic [2*W-1:0] y;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Latency counted in edges, the accepting edge being edge 1.
    function automatic int exp_lat(input logic [W-1:0] b, input logic s);
`ifdef MULT_ITER_EARLY_EXIT_EN
        logic [W-1:0] bm;
        int msb;
        bm  = (s && b[W-1]) ? (~b + 1'b1) : b;
        msb = -1;
        for (int i = 0; i < W; i++) if (bm[i]) msb = i;
        if (msb < 0) return 2;
        return (msb + DB) / DB + 1;
`else
        return W / DB + 1;
`endif
    endfunction

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          output logic [2*W-1:0] y, output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        in_a = a;
        in_b = b;
        in_signed = s;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a = $urandom;
        in_b = $urandom;
        in_signed = ~s;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        y = out_y;
        if (!out_valid) begin
            checks++;
            errors++;
            $display("FAIL op_timeout: got no out_valid required out_valid within 200 edges");
        end
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [2*W-1:0] y;
        logic [2*W-1:0] y_hold;
        logic [127:0]   ref_y;
        logic [W-1:0]   ra;
        logic [W-1:0]   rb;
        logic           rs;
        int             lat;
        bit             saw_valid;

        vecs[0]  = '{32'd4,          32'd6,          1'b1, 64'd24};
        vecs[1]  = '{32'h8000_0000,  32'h8000_0000,  1'b1, 64'h4000_0000_0000_0000};
        vecs[2]  = '{32'h7FFF_FFFF,  32'h8000_0000,  1'b1, 64'hC000_0000_8000_0000};
        vecs[3]  = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 64'hFFFF_FFFE_0000_0001};
        vecs[4]  = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1, 64'd1};
        vecs[5]  = '{32'd0,          32'hFFFF_FFFF,  1'b1, 64'd0};
        vecs[6]  = '{32'hFFFF_FFFD,  32'd5,          1'b1, 64'hFFFF_FFFF_FFFF_FFF1};
        vecs[7]  = '{32'hFFFF_FFFD,  32'd5,          1'b0, 64'h0000_0004_FFFF_FFF1};
        vecs[8]  = '{32'h1234_5678,  32'h10,         1'b0, 64'h0000_0001_2345_6780};
        vecs[9]  = '{32'h7FFF_FFFF,  32'h7FFF_FFFF,  1'b1, 64'h3FFF_FFFF_0000_0001};
        vecs[10] = '{32'd5,          32'd1,          1'b0, 64'd5};
        vecs[11] = '{32'd9,          32'd0,          1'b0, 64'd0};

        // Reset state
        #2;
        check("reset_in_ready", in_ready, 1'b1);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_out_y", out_y, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vector table
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].s, y, lat);
            check($sformatf("vec%0d_y", i), y, vecs[i].y);
            check($sformatf("vec%0d_latency", i), lat, exp_lat(vecs[i].b, vecs[i].s));
            release_out();
            check($sformatf("vec%0d_idle", i), in_ready, 1'b1);
        end

        // Back-pressure: DONE holds while new requests are presented
        run_op(32'd7, 32'd9, 1'b1, y_hold, lat);
        check("bp_y", y_hold, 64'd63);
        in_valid = 1'b1;
        in_a = 32'd11;
        in_b = 32'd13;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp_valid_%0d", c), out_valid, 1'b1);
            check($sformatf("bp_y_%0d", c), out_y, y_hold);
            check($sformatf("bp_in_ready_%0d", c), in_ready, 1'b0);
        end
        in_valid = 1'b0;
        release_out();
        check("bp_release_in_ready", in_ready, 1'b1);
        check("bp_release_out_valid", out_valid, 1'b0);

        // Asynchronous reset in the middle of CALC
        @(negedge clk);
        in_a = 32'd100;
        in_b = 32'hF000_0000;
        in_signed = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", out_valid, 1'b0);
        check("rst_mid_out_y", out_y, 64'd0);
        check("rst_mid_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        saw_valid = 1'b0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) saw_valid = 1'b1;
        end
        check("rst_no_stale_valid", saw_valid, 1'b0);
        run_op(32'd3, 32'd5, 1'b0, y, lat);
        check("post_rst_y", y, 64'd15);
        check("post_rst_latency", lat, exp_lat(32'd5, 1'b0));
        release_out();

        // Random sweep against the reference model
        for (int n = 0; n < 200; n++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            if (n % 10 == 0) rb = rb >> $urandom_range(0, 31);
            run_op(ra, rb, rs, y, lat);
            ref_y = mult_ref({32'd0, ra}, {32'd0, rb}, rs, W);
            check($sformatf("rand%0d_y a=%h b=%h s=%0d", n, ra, rb, rs), y, ref_y[2*W-1:0]);
            check($sformatf("rand%0d_latency", n), lat, exp_lat(rb, rs));
            release_out();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_iter.md
Name: mult_iter

Overview:
- Parametrised, multi-cycle signed/unsigned integer multiplier; successor to the combinational 32-bit multiplier.
- Consumes DIGIT_BITS multiplier bits per cycle (radix-2^DIGIT_BITS shift-add) and returns the full 2*WIDTH-bit product.
- Uses valid/ready handshakes on both sides.
- Sits beside the CPU ALU as the MUL/MUL-high execution unit; trades latency for area.

Parameters:
- WIDTH, 32, operand width in bits; must be divisible by DIGIT_BITS.
- DIGIT_BITS, 2, multiplier bits retired per CALC cycle; legal values 1, 2, 4.
- CNT_W, $clog2(WIDTH/DIGIT_BITS)+1, iteration counter width (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- in_a  in  WIDTH  multiplicand.
- in_b  in  WIDTH  multiplier.
- in_signed  in  1  1: operands are two's complement; 0: unsigned.
- out_valid  out  1  product valid.
- out_ready  in  1  consumer accepts product.
- out_y  out  2*WIDTH  product.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state=IDLE; in_ready=1; out_valid=0.
  - out_y=0; all internal accumulator, operand and counter registers = 0.
- States:
  - IDLE: in_ready=1, out_valid=0.
    - On in_valid&&in_ready: latch |a| and |b| (magnitude only when in_signed=1, else raw), neg_flag=in_signed&&(a[W-1]^b[W-1]), acc=0, cnt=WIDTH/DIGIT_BITS.
    - Transition -> CALC.
  - CALC: in_ready=0, out_valid=0.
    - Each cycle: acc += (mcand * b[DIGIT_BITS-1:0]) << shift; b >>= DIGIT_BITS; cnt--.
    - When cnt==1 at the clock edge: out_y = neg_flag ? -acc_next : acc_next; transition -> DONE.
  - DONE: out_valid=1; out_y held stable.
    - On out_ready: -> IDLE.
    - No new request is accepted in the same cycle.
- Latency: out_valid rises WIDTH/DIGIT_BITS+1 clock edges after the accepting edge (17 for defaults). Throughput is one product per latency+1 cycles minimum.
- Arithmetic:
  - Internal magnitude datapath is WIDTH bits unsigned, so |MININT| = 2^(WIDTH-1) is exact.
  - Accumulator is 2*WIDTH bits; no overflow is possible.
  - Negation is two's complement over 2*WIDTH bits.
- Signed MININT*MININT = +2^(2W-2); MAXINT*MININT is negative and exact.
- Zero operand is not special-cased: it runs the full latency (see optional feature).
- Inputs are ignored while not in IDLE; in_a/in_b may change after acceptance without effect.
- out_y must not change while out_valid=1 && !out_ready.
- rst_n asserted mid-CALC or in DONE:
  - Immediate return to IDLE with reset values.
  - The pending product is discarded; no out_valid pulse.

Optional Feature:
- Macro: MULT_ITER_EARLY_EXIT_EN.
- Defined: in CALC, if the remaining shifted multiplier is zero after the current digit, take the finishing transition to DONE immediately, regardless of cnt.
  - Latency becomes ceil(msb_index(|b|)+1 / DIGIT_BITS)+1 edges, minimum 2.
  - b=0 gives latency 2.
  - The product is bit-identical to the non-early-exit result.
- Undefined: latency is fixed at WIDTH/DIGIT_BITS+1 for all operands.

Decomposition:
- Package mult_pkg:
  - state_t enum {IDLE, CALC, DONE}.
  - Legal-DIGIT_BITS check constant/function.
  - Function mult_ref(a, b, signed) returning the 2*WIDTH golden product, shared with benches.
- One natural sub-module: mult_sign_fix.
  - Conditional two's-complement negate of a parametrised width.
  - Instantiated for operand magnitude (WIDTH) and result correction (2*WIDTH).

Test Plan:
- Reset then in_a=4, in_b=6, signed=1 -> out_y=24, out_valid exactly 17 edges after accept (defaults, no early exit).
- Signed MININT*MININT (0x80000000 each) -> out_y=0x4000_0000_0000_0000; signed MAXINT*MININT -> 0xC000_0000_8000_0000.
- Unsigned 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFF_FFFE_0000_0001; the same operands signed -> 1; signed 0*-1 -> 0.
- Back-pressure: hold out_ready=0 for 10 cycles in DONE -> out_valid and out_y stable, in_ready=0; release -> IDLE next cycle, in_ready=1.
- Assert rst_n low at CALC cycle 5 -> all outputs 0 asynchronously; no out_valid afterward; a subsequent request 3*5 -> 15.
- Random sweep, 1000 pairs, both modes, DIGIT_BITS in {1,2,4}, WIDTH in {8,32,64}, with MULT_ITER_EARLY_EXIT_EN on and off -> out_y matches mult_ref; early-exit b=1 -> latency 2.
